// File: rtl/uart_slip_framer.sv
// SLIP framer: buffers {last, byte} entries in a FIFO and streams C0-delimited,
// escaped frames to a UART transmitter, one byte per transmit strobe.
module uart_slip_framer #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  tx_byte,
  output logic        transmit,
  input  logic        tx_free,
  output logic        busy,
  output logic [15:0] frames_sent
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [7:0] SLIP_END     = 8'hC0;
  localparam logic [7:0] SLIP_ESC     = 8'hDB;
  localparam logic [7:0] SLIP_ESC_END = 8'hDC;
  localparam logic [7:0] SLIP_ESC_ESC = 8'hDD;

  typedef enum logic [2:0] {
    IDLE,
    SOF,
    DATA,
    ESC2,
    EOF
  } state_t;

  function automatic logic needs_esc(input logic [7:0] b);
    return (b == SLIP_END) || (b == SLIP_ESC);
  endfunction

  function automatic logic [7:0] esc_code(input logic [7:0] b);
    return (b == SLIP_END) ? SLIP_ESC_END : SLIP_ESC_ESC;
  endfunction

  logic [8:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        empty, full, wr_en, pop;
  logic [8:0]  head;

  state_t      state_q, state_d;
  logic [7:0]  esc_q, esc_d;
  logic        esc_last_q, esc_last_d;
  logic        tx_prev_q;
  logic [7:0]  tx_byte_q;
  logic [15:0] frames_q;

  logic        can_tx, issue, frame_done;
  logic [7:0]  issue_byte;

  // FIFO bookkeeping: the extra pointer bit tells full from empty.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full;
  assign wr_en    = in_valid && !full;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {in_last, in_data};
    end
  end

  // A byte goes out only with the UART idle and no strobe in the previous cycle.
  assign can_tx = tx_free && !tx_prev_q;

  always_comb begin
    state_d    = state_q;
    esc_d      = esc_q;
    esc_last_d = esc_last_q;
    issue      = 1'b0;
    issue_byte = tx_byte_q;
    pop        = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          state_d = SOF;
        end
      end
      SOF: begin
        if (can_tx) begin
          issue      = 1'b1;
          issue_byte = SLIP_END;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (can_tx && !empty) begin
          issue = 1'b1;
          pop   = 1'b1;
          if (needs_esc(head[7:0])) begin
            issue_byte = SLIP_ESC;
            esc_d      = esc_code(head[7:0]);
            esc_last_d = head[8];
            state_d    = ESC2;
          end else begin
            issue_byte = head[7:0];
            state_d    = head[8] ? EOF : DATA;
          end
        end
      end
      ESC2: begin
        if (can_tx) begin
          issue      = 1'b1;
          issue_byte = esc_q;
          state_d    = esc_last_q ? EOF : DATA;
        end
      end
      EOF: begin
        if (can_tx) begin
          issue      = 1'b1;
          issue_byte = SLIP_END;
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx_byte shows the byte being issued, then holds it until the next issue.
  assign transmit    = issue && !rst;
  assign tx_byte     = transmit ? issue_byte : tx_byte_q;
  assign busy        = (state_q != IDLE) || !empty;
  assign frames_sent = frames_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      tx_prev_q <= 1'b0;
      tx_byte_q <= 8'h00;
      frames_q  <= 16'h0000;
    end else begin
      state_q   <= state_d;
      tx_prev_q <= transmit;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
      end
      if (transmit) begin
        tx_byte_q <= issue_byte;
      end
      if (frame_done) begin
        frames_q <= frames_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    esc_q      <= esc_d;
    esc_last_q <= esc_last_d;
  end

endmodule

// File: tb/tb_uart_slip_framer.sv
// Directed bench for uart_slip_framer: records every transmit strobe and compares
// the emitted byte stream, pulse spacing, flow control and counters to hand values.
module tb_uart_slip_framer;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  tx_byte;
  logic        transmit;
  logic        tx_free;
  logic        busy;
  logic [15:0] frames_sent;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_cyc = -1;
  logic [7:0] exp_byte = 8'h00;

  logic [7:0] txq [$];
  int         txc [$];
  logic [7:0] expq [$];

  uart_slip_framer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .tx_byte    (tx_byte),
    .transmit   (transmit),
    .tx_free    (tx_free),
    .busy       (busy),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe recorder: captures issued bytes, checks spacing and tx_byte hold.
  always @(negedge clk) begin
    if (rst) begin
      exp_byte = 8'h00;
    end else if (transmit) begin
      txq.push_back(tx_byte);
      txc.push_back(cyc);
      if (last_cyc >= 0) chk("tx_spacing", 32'(cyc - last_cyc >= 2), 32'd1);
      last_cyc = cyc;
      exp_byte = tx_byte;
    end else begin
      chk("tx_byte_hold", 32'(tx_byte), 32'(exp_byte));
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic l);
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_frames(input string tag, input logic [15:0] n);
    int k = 0;
    while (frames_sent !== n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(frames_sent), 32'(n));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tx_count(input string tag, input int n);
    int k = 0;
    while (txq.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(txq.size()), 32'(n));
  endtask

  task automatic expect_seq(input string tag, input int gap_from);
    int n;
    chk({tag, "_len"}, 32'(txq.size()), 32'(expq.size()));
    n = (txq.size() < expq.size()) ? txq.size() : expq.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), 32'(txq[i]), 32'(expq[i]));
    end
    for (int i = (gap_from < 1 ? 1 : gap_from); i < n; i++) begin
      chk($sformatf("%s_gap%0d", tag, i), 32'(txc[i] - txc[i-1]), 32'd2);
    end
    txq.delete();
    txc.delete();
    expq.delete();
  endtask

  initial begin
    int acc;
    rst      = 1'b1;
    in_data  = 8'h00;
    in_last  = 1'b0;
    in_valid = 1'b0;
    tx_free  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_transmit", 32'(transmit), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frames", 32'(frames_sent), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Plain two-byte frame
    send_byte(8'h41, 1'b0);
    send_byte(8'h42, 1'b1);
    wait_frames("f1_frames", 16'd1);
    chk("f1_busy", 32'(busy), 32'd0);
    expq = '{8'hC0, 8'h41, 8'h42, 8'hC0};
    expect_seq("f1", 1);

    // Both escapable bytes
    send_byte(8'hC0, 1'b0);
    send_byte(8'hDB, 1'b1);
    wait_frames("f2_frames", 16'd2);
    expq = '{8'hC0, 8'hDB, 8'hDC, 8'hDB, 8'hDD, 8'hC0};
    expect_seq("f2", 1);

    // UART stalls for 100 cycles after the opening delimiter
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b1);
    wait_tx_count("hold_first", 1);
    @(posedge clk);
    #1;
    tx_free = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("hold_no_pulse", 32'(txq.size()), 32'd1);
    chk("hold_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    tx_free = 1'b1;
    wait_frames("hold_frames", 16'd3);
    expq = '{8'hC0, 8'h11, 8'h22, 8'hC0};
    expect_seq("hold", 2);

    // Overfill the FIFO while the UART is busy
    tx_free  = 1'b0;
    acc      = 0;
    in_valid = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      in_data = 8'(i + 1);
      in_last = (i == DEPTH - 1);
      @(negedge clk);
      if (i == DEPTH - 1) chk("ovf_ready_before_full", 32'(in_ready), 32'd1);
      if (i == DEPTH)     chk("ovf_ready_full", 32'(in_ready), 32'd0);
      if (in_ready) acc++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("ovf_accepted", 32'(acc), 32'(DEPTH));
    tx_free = 1'b1;
    wait_frames("ovf_frames", 16'd4);
    expq.push_back(8'hC0);
    for (int i = 1; i <= DEPTH; i++) expq.push_back(8'(i));
    expq.push_back(8'hC0);
    expect_seq("ovf", 1);

    // Reset after the third output byte of a six-byte frame
    tx_free = 1'b0;
    for (int i = 0; i < 6; i++) send_byte(8'(8'h31 + i), i == 5);
    tx_free = 1'b1;
    wait_tx_count("rstmid_third", 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("rstmid_transmit", 32'(transmit), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_in_ready", 32'(in_ready), 32'd1);
    chk("rstmid_frames", 32'(frames_sent), 32'd0);
    expq = '{8'hC0, 8'h31, 8'h32};
    expect_seq("rstmid", 1);
    @(posedge clk);
    #1;
    send_byte(8'h55, 1'b1);
    wait_frames("after_rst_frames", 16'd1);
    expq = '{8'hC0, 8'h55, 8'hC0};
    expect_seq("after_rst", 1);

    // Counter wrap, preloading the count just below the top
    force dut.frames_q = 16'hFFFE;
    @(negedge clk);
    release dut.frames_q;
    @(posedge clk);
    #1;
    chk("wrap_preload", 32'(frames_sent), 32'h0000FFFE);
    send_byte(8'h77, 1'b1);
    wait_frames("wrap_ffff", 16'hFFFF);
    send_byte(8'h78, 1'b1);
    wait_frames("wrap_zero", 16'h0000);
    expq = '{8'hC0, 8'h77, 8'hC0, 8'hC0, 8'h78, 8'hC0};
    expect_seq("wrap", 1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_slip_framer.md
UART_SLIP_FRAMER -- requirements
Module: uart_slip_framer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning FIFO entry count (power of two, 4..256).
REQ-002 SHALL have port clk, input, 1, clock.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port in_data, input, 8, payload byte from upstream.
REQ-005 SHALL have port in_last, input, 1, marks final byte of a frame.
REQ-006 SHALL have port in_valid, input, 1, upstream byte valid.
REQ-007 SHALL have port in_ready, output, 1, FIFO can accept a byte.
REQ-008 SHALL have port tx_byte, output, 8, byte offered to the UART transmitter.
REQ-009 SHALL have port transmit, output, 1, single-cycle send strobe to the UART.
REQ-010 SHALL have port tx_free, input, 1, UART transmitter idle.
REQ-011 SHALL have port busy, output, 1, frame in progress or FIFO non-empty.
REQ-012 SHALL have port frames_sent, output, 16, count of completed frames.

Function
REQ-013 SHALL store {in_last, in_data} in a DEPTH-entry FIFO on any cycle with in_valid && in_ready.
REQ-014 SHALL drive in_ready = !full, combinationally from registered FIFO state; a write and a pop in the same cycle when full SHALL NOT be accepted (in_ready stays 0).
REQ-015 SHALL SLIP-encode: frame = 0xC0, escaped payload, 0xC0; 0xC0 -> 0xDB 0xDC; 0xDB -> 0xDB 0xDD; all other bytes unchanged.
REQ-016 SHALL implement FSM states IDLE, SOF, DATA, ESC2, EOF.
REQ-017 IDLE: FIFO non-empty -> SOF with pending byte 0xC0.
REQ-018 SOF: after 0xC0 issued -> DATA.
REQ-019 DATA: pop FIFO head; if 0xC0 or 0xDB, issue 0xDB then -> ESC2 with pending 0xDC/0xDD; else issue byte; after the byte (or ESC2 second byte), head in_last=1 -> EOF, otherwise DATA.
REQ-020 DATA with FIFO empty SHALL wait (no transmit, no frame abort); the FIFO head SHALL be popped only in the cycle its first output byte is issued.
REQ-021 EOF: after 0xC0 issued -> IDLE and frames_sent increments by 1, wrapping 0xFFFF -> 0x0000.
REQ-022 A byte SHALL be issued by asserting transmit for exactly one cycle with tx_byte valid in that cycle, only when tx_free=1 and transmit was 0 in the previous cycle.
REQ-023 tx_byte SHALL remain stable from the issuing cycle until the next issue.
REQ-024 Minimum spacing between transmit pulses SHALL be 2 cycles; with tx_free held 1 the framer SHALL issue one byte every 2 cycles.
REQ-025 busy SHALL be 1 when the FSM is not IDLE or the FIFO is non-empty.
REQ-026 An in_last=1 byte SHALL end the frame even if it is the first payload byte; a zero-length frame is not representable and SHALL NOT be generated.

Reset
REQ-027 On rst: FSM IDLE, FIFO empty, in_ready=1, transmit=0, tx_byte=0x00, busy=0, frames_sent=0.
REQ-028 rst mid-frame SHALL discard FIFO contents and the partial frame without emitting a closing 0xC0; rst has priority over all writes.

Verification
REQ-029 Frame {0x41,0x42(last)}, tx_free=1 -> transmit pulses carry 0xC0,0x41,0x42,0xC0, 2 cycles apart; frames_sent=1.
REQ-030 Frame {0xC0,0xDB(last)} -> bytes 0xC0,0xDB,0xDC,0xDB,0xDD,0xC0.
REQ-031 tx_free held 0 for 100 cycles after first byte -> no transmit pulses during hold; sequence resumes unchanged after release.
REQ-032 Write DEPTH+4 bytes with tx_free=0 -> in_ready=0 after DEPTH writes, excess not stored; released stream contains exactly DEPTH payload bytes.
REQ-033 rst asserted after 3rd output byte of a 6-byte frame -> transmit stays 0, busy=0, next frame starts with 0xC0.
REQ-034 65536 single-byte frames -> frames_sent wraps to 0x0000.
